// File: rtl/clk_meter_if.sv
// clk_meter_if: signal bundle between the slow-clock source side and the clock meter.
// master: drives clk_in/prog_ref and observes the measurement results.
// slave : the meter itself, samples clk_in/prog_ref and drives the results.
interface clk_meter_if;
  logic        clk_in;
  logic [2:0]  prog_ref;
  logic [31:0] period;
  logic        meas_done;
  logic [2:0]  prog_out;
  logic        valid;
  logic        err;
  logic        mismatch;
  logic        lost;
  modport master (
    output clk_in, prog_ref,
    input  period, meas_done, prog_out, valid, err, mismatch, lost
  );
  modport slave (
    input  clk_in, prog_ref,
    output period, meas_done, prog_out, valid, err, mismatch, lost
  );
endinterface

// File: rtl/clk_meter.sv
// clk_meter: measures the period of a slow clock in clk cycles and decodes it into a 3-bit program code.
// Ports: clk (system clock), rst (sync, active-low), bus (clk_meter_if.slave):
//   clk_in/prog_ref in; period, meas_done, prog_out, valid, err, mismatch, lost out.
module clk_meter #(
  parameter logic [31:0] TICK_CYCLES    = 32'd10_000_000,
  parameter logic [31:0] TOL_CYCLES     = 32'd100_000,
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd2_560_000_000
) (
  input logic        clk,
  input logic        rst,
  clk_meter_if.slave bus
);
  typedef enum logic [1:0] {SYNC, MEAS, LOST} state_t;
  state_t      state_q, state_d;
  logic        sync1_q, sync2_q, dly_q;
  logic [31:0] cnt_q, cnt_d, period_q, period_d;
  logic        meas_done_q, meas_done_d, valid_q, valid_d, err_q, err_d, lost_q, lost_d;
  logic        cand_v_q, cand_v_d;
  logic [2:0]  prog_q, prog_d, cand_q, cand_d, hit_code;
  logic [31:0] nom [8];
  logic [7:0]  match;
  logic        rise, hit, timeout;
  assign rise    = sync2_q & ~dly_q;
  assign timeout = cnt_q >= TIMEOUT_CYCLES;
  // Absolute difference is formed by ordering the operands, so neither side can wrap.
  genvar g;
  for (g = 0; g < 8; g++) begin : g_nom
    assign nom[g]   = TICK_CYCLES << g;
    assign match[g] = ((cnt_q >= nom[g]) ? cnt_q - nom[g] : nom[g] - cnt_q) <= TOL_CYCLES;
  end
  // Scan downward so the lowest matching code ends up selected.
  always_comb begin
    hit      = |match;
    hit_code = '0;
    for (int i = 7; i >= 0; i--) if (match[i]) hit_code = 3'(i);
  end
  assign cnt_d = rise ? 32'd1 : (timeout ? cnt_q : cnt_q + 32'd1);
  always_comb begin
    state_d     = state_q;
    period_d    = period_q;
    meas_done_d = 1'b0;
    prog_d      = prog_q;
    valid_d     = valid_q;
    err_d       = err_q;
    lost_d      = lost_q;
    cand_d      = cand_q;
    cand_v_d    = cand_v_q;
    case (state_q)
      SYNC: state_d = rise ? MEAS : SYNC;
      MEAS: begin
        if (rise) begin
          period_d    = cnt_q;
          meas_done_d = 1'b1;
          err_d       = ~hit;
          // A code is only published once two consecutive periods agree on it.
          if (hit && cand_v_q && cand_q == hit_code) begin
            prog_d  = hit_code;
            valid_d = 1'b1;
          end else begin
            valid_d  = 1'b0;
            cand_d   = hit ? hit_code : 3'd0;
            cand_v_d = hit;
          end
        end else if (timeout) begin
          state_d  = LOST;
          lost_d   = 1'b1;
          valid_d  = 1'b0;
          cand_d   = '0;
          cand_v_d = 1'b0;
        end
      end
      LOST: begin
        state_d = rise ? MEAS : LOST;
        lost_d  = ~rise;
      end
      default: state_d = SYNC;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= SYNC;
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      dly_q       <= 1'b0;
      cnt_q       <= '0;
      period_q    <= '0;
      meas_done_q <= 1'b0;
      prog_q      <= '0;
      valid_q     <= 1'b0;
      err_q       <= 1'b0;
      lost_q      <= 1'b0;
      cand_q      <= '0;
      cand_v_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      sync1_q     <= bus.clk_in;
      sync2_q     <= sync1_q;
      dly_q       <= sync2_q;
      cnt_q       <= cnt_d;
      period_q    <= period_d;
      meas_done_q <= meas_done_d;
      prog_q      <= prog_d;
      valid_q     <= valid_d;
      err_q       <= err_d;
      lost_q      <= lost_d;
      cand_q      <= cand_d;
      cand_v_q    <= cand_v_d;
    end
  end
  assign bus.period    = period_q;
  assign bus.meas_done = meas_done_q;
  assign bus.prog_out  = prog_q;
  assign bus.valid     = valid_q;
  assign bus.err       = err_q;
  assign bus.lost      = lost_q;
  assign bus.mismatch  = valid_q & (prog_q != bus.prog_ref);
endmodule
